// File: rtl/symbol_sequencer.sv
// symbol_sequencer
//   Source side of the symbol-counting game. Draws a pseudo-random symbol
//   stream from a free-running 16-bit Galois LFSR. Each symbol is shown for
//   DWELL_CYCLES, followed by GAP_CYCLES of blank. The block counts how many
//   times the latched magic symbol is emitted, and frames each round with
//   single-cycle start/stop pulses.
//
// Ports
//   Clk100M          in   system clock, rising edge
//   Reset            in   asynchronous active-high reset
//   go               in   request a new round (honoured only in IDLE/DONE)
//   magicSymbol      in   target symbol, latched when a round launches
//   symbol           out  currently displayed symbol code
//   symbolValid      out  high while a symbol is displayed
//   start            out  one-cycle pulse on the first cycle of a round
//   stop             out  one-cycle pulse on the first DONE cycle
//   magicSymbolCount out  magic symbols emitted this round (saturates at 255)
//   busy             out  high while a round is in progress
//   done             out  high after a round completes, until the next go
//
// Optional build macro
//   SYMSEQ_NO_REPEAT_EN : when defined, a draw that equals the previously
//   displayed symbol is bumped by one (mod 2^SYMBOL_W). This never applies
//   to the first symbol of a round.
//
// State | meaning
//   IDLE | waiting for go after reset
//   SHOW | symbol displayed, dwell timer running
//   GAP  | blank between symbols, gap timer running
//   DONE | round finished, count and symbol held

module symbol_sequencer #(
  parameter int          SYMBOL_W     = 3,
  parameter int          NUM_SYMBOLS  = 16,
  parameter int          DWELL_CYCLES = 50000000,
  parameter int          GAP_CYCLES   = 10000000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                Clk100M,
  input  logic                Reset,
  input  logic                go,
  input  logic [SYMBOL_W-1:0] magicSymbol,
  output logic [SYMBOL_W-1:0] symbol,
  output logic                symbolValid,
  output logic                start,
  output logic                stop,
  output logic [7:0]          magicSymbolCount,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  localparam logic [31:0] DWELL_LOAD = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);
  localparam logic [7:0]  LAST_IDX   = 8'(NUM_SYMBOLS - 1);

  state_t              state, state_next;
  logic [15:0]         lfsr, lfsr_next;
  logic [31:0]         timer, timer_next;
  logic [7:0]          idx, idx_next;
  logic [SYMBOL_W-1:0] magic, magic_next;
  logic [SYMBOL_W-1:0] symbol_next, raw_draw, draw;
  logic [7:0]          count_next;
  logic                start_next, stop_next;

  // Right-shifting Galois form; it runs in every state, so round content
  // depends on when go arrives.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign raw_draw  = lfsr[SYMBOL_W-1:0];

`ifdef SYMSEQ_NO_REPEAT_EN
  // Draws taken in GAP are always idx>0. The register symbol still holds
  // the previously displayed value.
  assign draw = (state == GAP && raw_draw == symbol) ? raw_draw + SYMBOL_W'(1) : raw_draw;
`else
  assign draw = raw_draw;
`endif

  assign symbolValid = (state == SHOW);
  assign busy        = (state == SHOW) || (state == GAP);
  assign done        = (state == DONE);

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    idx_next    = idx;
    magic_next  = magic;
    symbol_next = symbol;
    count_next  = magicSymbolCount;
    start_next  = 1'b0;
    stop_next   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_next  = SHOW;
          timer_next  = DWELL_LOAD;
          idx_next    = 8'd0;
          magic_next  = magicSymbol;
          symbol_next = draw;
          count_next  = (draw == magicSymbol) ? 8'd1 : 8'd0;
          start_next  = 1'b1;
        end
      end
      SHOW: begin
        if (timer == 32'd0) begin
          state_next = GAP;
          timer_next = GAP_LOAD;
        end else begin
          timer_next = timer - 32'd1;
        end
      end
      GAP: begin
        if (timer == 32'd0) begin
          if (idx < LAST_IDX) begin
            state_next  = SHOW;
            timer_next  = DWELL_LOAD;
            idx_next    = idx + 8'd1;
            symbol_next = draw;
            if (draw == magic && magicSymbolCount != 8'hFF)
              count_next = magicSymbolCount + 8'd1;
          end else begin
            state_next = DONE;
            stop_next  = 1'b1;
          end
        end else begin
          timer_next = timer - 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      lfsr             <= LFSR_SEED;
      timer            <= 32'd0;
      idx              <= 8'd0;
      magic            <= '0;
      symbol           <= '0;
      magicSymbolCount <= 8'd0;
      start            <= 1'b0;
      stop             <= 1'b0;
    end else begin
      state            <= state_next;
      lfsr             <= lfsr_next;
      timer            <= timer_next;
      idx              <= idx_next;
      magic            <= magic_next;
      symbol           <= symbol_next;
      magicSymbolCount <= count_next;
      start            <= start_next;
      stop             <= stop_next;
    end
  end

endmodule

// File: tb/tb_symbol_sequencer.sv
// Testbench for symbol_sequencer. A round-level model predicts every output
// from the go cycle, the latched magic symbol and the LFSR value history.
// The model is checked on each falling edge, and directed literal
// expectations pin it down.
module tb_symbol_sequencer;
  localparam int SW  = 3;
  localparam int N   = 4;
  localparam int D   = 3;
  localparam int G   = 2;
  localparam int P   = D + G;
  localparam int RL  = N * P;
  localparam int LEN = 8192;

  logic          Clk100M = 1'b0;
  logic          Reset = 1'b1;
  logic          go = 1'b0;
  logic [SW-1:0] magicSymbol = '0;
  logic [SW-1:0] symbol;
  logic          symbolValid, start, stop, busy, done;
  logic [7:0]    magicSymbolCount;

  symbol_sequencer #(
    .SYMBOL_W(SW), .NUM_SYMBOLS(N), .DWELL_CYCLES(D), .GAP_CYCLES(G), .LFSR_SEED(16'hACE1)
  ) dut (
    .Clk100M(Clk100M), .Reset(Reset), .go(go), .magicSymbol(magicSymbol),
    .symbol(symbol), .symbolValid(symbolValid), .start(start), .stop(stop),
    .magicSymbolCount(magicSymbolCount), .busy(busy), .done(done)
  );

  always #5 Clk100M = ~Clk100M;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [15:0] lfsr_at [LEN];

  bit          has_round = 1'b0;
  int          t_go = 0;
  logic [SW-1:0] m_magic = '0;
  logic [SW+12:0] exp_v, got_v;

  always @(posedge Clk100M or posedge Reset)
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Symbol emitted in slot s of a round launched at cycle t.
  function automatic logic [SW-1:0] emit(input int t, input int s);
    logic [SW-1:0] raw, prev;
    logic [15:0]   v;
    prev = '0;
    for (int k = 0; k <= s; k++) begin
      v = lfsr_at[t + k * P];
      raw = v[SW-1:0];
`ifdef SYMSEQ_NO_REPEAT_EN
      if (k > 0 && raw == prev) raw = raw + SW'(1);
`endif
      prev = raw;
    end
    return prev;
  endfunction

  function automatic int mcount(input int t, input int s, input logic [SW-1:0] m);
    int n = 0;
    for (int k = 0; k <= s; k++)
      if (emit(t, k) == m && n < 255) n++;
    return n;
  endfunction

  function automatic logic [SW+12:0] model_out(input int c);
    logic [SW-1:0] sy;
    logic v, st, sp, b, d;
    logic [7:0] cnt;
    int r, s;
    sy = '0; v = 0; st = 0; sp = 0; b = 0; d = 0; cnt = 8'd0;
    if (has_round) begin
      r = c - t_go;
      if (r <= RL) begin
        s   = (r - 1) / P;
        sy  = emit(t_go, s);
        v   = ((r - 1) % P) < D;
        st  = (r == 1);
        b   = 1'b1;
        cnt = 8'(mcount(t_go, s, m_magic));
      end else begin
        sy  = emit(t_go, N - 1);
        sp  = (r == RL + 1);
        d   = 1'b1;
        cnt = 8'(mcount(t_go, N - 1, m_magic));
      end
    end
    return {sy, v, st, sp, cnt, b, d};
  endfunction

  always @(negedge Clk100M) begin
    got_v = {symbol, symbolValid, start, stop, magicSymbolCount, busy, done};
    if (Reset) begin
      checks++;
      if (got_v != '0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got %h expected 0", $time, got_v);
      end
      has_round = 1'b0;
    end else begin
      if (cyc >= LEN - 2 * RL) begin
        $display("FAIL cycle_budget cyc=%0d exceeds model table %0d", cyc, LEN - 2 * RL);
        $fatal(1, "model table exhausted");
      end
      exp_v = model_out(cyc);
      checks++;
      if (got_v != exp_v) begin
        errors++;
        $display("FAIL per_cycle cyc=%0d got {sym,val,start,stop,cnt,busy,done}=%h expected %h",
                 cyc, got_v, exp_v);
      end
      if (go && !(has_round && (cyc - t_go) >= 1 && (cyc - t_go) <= RL)) begin
        has_round = 1'b1;
        t_go      = cyc;
        m_magic   = magicSymbol;
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < LEN) begin
      @(posedge Clk100M); #1;
      guard++;
    end
    if (cyc != c) chk("wait_cyc_reached", cyc, c);
  endtask

  task automatic launch(input int t, input logic [SW-1:0] m);
    wait_cyc(t);
    go = 1'b1;
    magicSymbol = m;
    wait_cyc(t + 1);
    go = 1'b0;
  endtask

  function automatic int find_magic(input int from);
    logic [SW-1:0] e0;
    for (int t = from; t < LEN - 3 * RL; t++) begin
      e0 = emit(t, 0);
      if (emit(t, 2) == e0 && emit(t, 1) != e0 && emit(t, 3) != e0) return t;
    end
    return -1;
  endfunction

  function automatic int find_repeat5(input int from);
    logic [15:0] a, b;
    for (int t = from; t < LEN - 3 * RL; t++) begin
      a = lfsr_at[t];
      b = lfsr_at[t + P];
      if (a[2:0] == 3'd5 && b[2:0] == 3'd5) return t;
    end
    return -1;
  endfunction

  int T;
  logic [SW-1:0] e0, e1;

  initial begin
    lfsr_at[0] = 16'hACE1;
    for (int i = 1; i < LEN; i++) lfsr_at[i] = lfsr_step(lfsr_at[i-1]);
    chk("model_lfsr_1", int'(lfsr_at[1]), 16'hE270);
    chk("model_lfsr_3", int'(lfsr_at[3]), 16'h389C);
    chk("model_lfsr_5", int'(lfsr_at[5]), 16'h0E27);

    // First round launched in cycle 0 after reset: draws come from ACE1 then 0E27.
    repeat (3) @(posedge Clk100M);
    #1 Reset = 1'b0;
    go = 1'b1;
    wait_cyc(1);
    go = 1'b0;
    chk("first_start", int'(start), 1);
    chk("first_symbol", int'(symbol), 1);
    wait_cyc(6);
    chk("second_symbol", int'(symbol), 7);
    chk("second_valid", int'(symbolValid), 1);

    // Reset mid-SHOW: outputs clear immediately, LFSR restarts at the seed.
    wait_cyc(7);
    Reset = 1'b1;
    #1;
    chk("reset_async_outputs",
        int'({symbol, symbolValid, start, stop, magicSymbolCount, busy, done}), 0);
    @(posedge Clk100M); #1;
    Reset = 1'b0;
    go = 1'b1;
    wait_cyc(1);
    go = 1'b0;
    chk("restart_symbol", int'(symbol), 1);
    wait_cyc(RL + 1);
    chk("basic_stop", int'(stop), 1);
    chk("basic_done", int'(done), 1);
    wait_cyc(RL + 2);
    chk("basic_stop_single", int'(stop), 0);

    // Magic counting with ignored go / magicSymbol changes mid-round.
    T = find_magic(cyc + 2);
    if (T < 0) chk("find_magic_slot", T, 0);
    else begin
      e0 = emit(T, 0);
      e1 = emit(T, 1);
      launch(T, e0);
      chk("magic_cnt_s0", int'(magicSymbolCount), 1);
      wait_cyc(T + 2);
      go = 1'b1;
      magicSymbol = e1;
      wait_cyc(T + 3);
      go = 1'b0;
      wait_cyc(T + 5);
      go = 1'b1;
      wait_cyc(T + 6);
      go = 1'b0;
      chk("magic_cnt_s1", int'(magicSymbolCount), 1);
      chk("ignored_go_no_start", int'(start), 0);
      wait_cyc(T + 11);
      chk("magic_cnt_s2", int'(magicSymbolCount), 2);
      wait_cyc(T + 16);
      chk("magic_cnt_s3", int'(magicSymbolCount), 2);
      wait_cyc(T + RL + 1);
      chk("magic_stop", int'(stop), 1);
      chk("magic_cnt_stop", int'(magicSymbolCount), 2);
      wait_cyc(T + RL + 3);
      chk("magic_cnt_held", int'(magicSymbolCount), 2);
      chk("magic_done_held", int'(done), 1);
    end

    // Back-to-back: go in the first DONE cycle.
    T = cyc + 2;
    launch(T, 3'd2);
    wait_cyc(T + RL + 1);
    chk("b2b_stop", int'(stop), 1);
    chk("b2b_no_start_at_stop", int'(start), 0);
    go = 1'b1;
    magicSymbol = 3'd4;
    wait_cyc(T + RL + 2);
    go = 1'b0;
    chk("b2b_start", int'(start), 1);
    chk("b2b_no_stop_at_start", int'(stop), 0);
    chk("b2b_done_dropped", int'(done), 0);
    wait_cyc(T + 2 * RL + 3);
    chk("b2b_second_done", int'(done), 1);

    // Consecutive raw draws of 5.
    T = find_repeat5(cyc + 2);
    if (T < 0) chk("find_repeat5", T, 0);
    else begin
      launch(T, 3'd5);
      chk("repeat_sym0", int'(symbol), 5);
      wait_cyc(T + P + 1);
`ifdef SYMSEQ_NO_REPEAT_EN
      chk("repeat_sym1", int'(symbol), 6);
      chk("repeat_cnt", int'(magicSymbolCount), 1);
`else
      chk("repeat_sym1", int'(symbol), 5);
      chk("repeat_cnt", int'(magicSymbolCount), 2);
`endif
      wait_cyc(T + RL + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(LEN * 10 * 4);
    $display("FAIL global_timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
